// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, register names and address decoder for the register file
package regfile_pkg;

  localparam int REG_W  = 32;
  localparam int REG_AW = 5;
  localparam int REG_N  = 2 ** REG_AW;

  // Architectural register names used by the datapath and the display.
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_SP   = 5'd29;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

  // Plain address-to-one-hot decode; the write gate and the r0 mask are applied by the caller.
  function automatic logic [REG_N-1:0] onehot_dec(input logic [REG_AW-1:0] addr);
    onehot_dec       = '0;
    onehot_dec[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wdec.sv
// rtl/regfile_wdec.sv - write-enable decoder with we gate and register 0 masked off
module regfile_wdec
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_AW,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  output logic [NREG-1:0]   en
);

  logic [NREG-1:0] dec;

  // Reuse the shared decoder when the geometry matches the package, otherwise decode locally.
  generate
    if (ADDR_W == REG_AW && NREG == REG_N) begin : g_pkg_dec
      assign dec = onehot_dec(wa);
    end else begin : g_loop_dec
      // Generic one-hot decode for non-default geometries.
      always_comb begin
        dec = '0;
        for (int k = 0; k < NREG; k++) begin
          dec[k] = (wa == ADDR_W'(k));
        end
      end
    end
  endgenerate

  // Gate with we and keep bit 0 low so register 0 can never be written.
  always_comb begin
    en = '0;
    if (we) begin
      en = dec & ~NREG'(1);
    end
  end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - MIPS register file: one write port, two forwarding read ports, one display port
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_W,
  parameter int ADDR_W = REG_AW,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic [ADDR_W-1:0] dbg_a,
  output logic [WIDTH-1:0]  dbg_d,
  output logic [NREG-1:0]   wr_hit
);

  logic [WIDTH-1:0] mem [NREG];
  logic [NREG-1:0]  en;

  regfile_wdec #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_wdec (
    .we (we),
    .wa (wa),
    .en (en)
  );

  // Storage: each enabled register captures wd; en[0] is always low so entry 0 stays at its reset zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (en[k]) begin
          mem[k] <= wd;
        end
      end
    end
  end

  // Trace of the last committed write; zero after an idle cycle or a dropped r0 write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_hit <= '0;
    end else begin
      wr_hit <= en;
    end
  end

  // Read port 1: r0 reads zero, a same-cycle write to the address is forwarded, else storage.
  always_comb begin
    rd1 = mem[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end
  end

  // Read port 2: same selection as port 1 so equal addresses always give equal data.
  always_comb begin
    rd2 = mem[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end
  end

  // Display port shows committed state only, so no forwarding here.
  always_comb begin
    dbg_d = mem[dbg_a];
    if (dbg_a == '0) begin
      dbg_d = '0;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile: vector table, corner sequences, random vs model
module tb_regfile;

  logic        clk;
  logic        clk_run;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [4:0]  dbg_a;
  logic [31:0] dbg_d;
  logic [31:0] wr_hit;

  int checks;
  int errors;

  regfile dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd1    (rd1),
    .rd2    (rd2),
    .dbg_a  (dbg_a),
    .dbg_d  (dbg_d),
    .wr_hit (wr_hit)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_a;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_dbg_pre;
    logic [31:0] exp_dbg_post;
    logic [31:0] exp_hit;
  } vec_t;

  vec_t vecs [9];

  logic [31:0] model [32];
  logic [31:0] exp_hit;
  logic [31:0] e1;
  logic [31:0] e2;
  logic [31:0] ed;

  initial begin
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_a = '0;

    // we wa wd ra1 ra2 dbg rd1 rd2 dbg_pre dbg_post hit
    vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd0,  5'd5,  32'h1234_5678, 32'h0,         32'h0,         32'h1234_5678, 32'h0000_0020};
    vecs[1] = '{1'b0, 5'd5,  32'h0,         5'd5,  5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
    vecs[3] = '{1'b1, 5'd8,  32'hAAAA_AAAA, 5'd8,  5'd5,  5'd8,  32'hAAAA_AAAA, 32'h1234_5678, 32'h0,         32'hAAAA_AAAA, 32'h0000_0100};
    vecs[4] = '{1'b1, 5'd8,  32'h5555_5555, 5'd8,  5'd8,  5'd8,  32'h5555_5555, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0100};
    vecs[5] = '{1'b1, 5'd3,  32'h3,         5'd0,  5'd3,  5'd3,  32'h0,         32'h3,         32'h0,         32'h3,         32'h0000_0008};
    vecs[6] = '{1'b1, 5'd4,  32'h4,         5'd3,  5'd4,  5'd4,  32'h3,         32'h4,         32'h0,         32'h4,         32'h0000_0010};
    vecs[7] = '{1'b0, 5'd4,  32'h9,         5'd4,  5'd3,  5'd3,  32'h4,         32'h3,         32'h3,         32'h3,         32'h0};
    vecs[8] = '{1'b1, 5'd31, 32'h0000_00FF, 5'd31, 5'd29, 5'd31, 32'h0000_00FF, 32'h0,         32'h0,         32'h0000_00FF, 32'h8000_0000};

    // Reset with no clock edges at all.
    rst_n = 1'b0;
    #3;
    for (int a = 0; a < 32; a++) begin
      dbg_a = 5'(a);
      #1;
      check($sformatf("reset_dbg_%0d", a), dbg_d, 32'h0);
    end
    check("reset_wr_hit", wr_hit, 32'h0);
    rst_n = 1'b1;
    #2;
    clk_run = 1'b1;
    #2;

    // Vector table: combinational reads before the edge, committed state after it.
    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2; dbg_a = vecs[i].dbg_a;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp_rd1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp_rd2);
      check($sformatf("vec%0d_dbg_pre", i), dbg_d, vecs[i].exp_dbg_pre);
      tick();
      we = 1'b0;
      #1;
      check($sformatf("vec%0d_dbg_post", i), dbg_d, vecs[i].exp_dbg_post);
      check($sformatf("vec%0d_wr_hit", i), wr_hit, vecs[i].exp_hit);
    end

    // Async reset between edges clears r31 immediately; forwarding still works during reset.
    dbg_a = 5'd31;
    #1;
    check("pre_reset_r31", dbg_d, 32'h0000_00FF);
    rst_n = 1'b0;
    #1;
    check("async_reset_r31", dbg_d, 32'h0);
    check("async_reset_hit", wr_hit, 32'h0);
    we = 1'b1; wa = 5'd7; wd = 32'h77; ra1 = 5'd7; ra2 = 5'd31;
    #1;
    check("reset_fwd_rd1", rd1, 32'h77);
    check("reset_fwd_rd2", rd2, 32'h0);
    tick();
    dbg_a = 5'd7;
    #1;
    check("reset_write_lost", dbg_d, 32'h0);
    rst_n = 1'b1;
    tick();
    check("first_write_after_reset", dbg_d, 32'h77);
    check("first_write_hit", wr_hit, 32'h0000_0080);

    // Back-to-back writes to one address: last edge wins.
    wd = 32'h1;
    tick();
    wd = 32'h2;
    tick();
    we = 1'b0;
    #1;
    check("b2b_last_wins", dbg_d, 32'h2);
    tick();
    check("idle_hit_zero", wr_hit, 32'h0);

    // Randomized phase against an array model, from a fresh reset.
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom);
      wa    = 5'($urandom_range(0, 31));
      wd    = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2   = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      dbg_a = 5'($urandom_range(0, 31));
      #1;
      e1 = (ra1 == 0) ? 32'h0 : ((we && wa == ra1) ? wd : model[ra1]);
      e2 = (ra2 == 0) ? 32'h0 : ((we && wa == ra2) ? wd : model[ra2]);
      ed = (dbg_a == 0) ? 32'h0 : model[dbg_a];
      check("rand_rd1", rd1, e1);
      check("rand_rd2", rd2, e2);
      check("rand_dbg", dbg_d, ed);
      exp_hit = (we && wa != 0) ? (32'h1 << wa) : 32'h0;
      if (we && wa != 0) model[wa] = wd;
      tick();
      check("rand_wr_hit", wr_hit, exp_hit);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
